// File: rtl/connect4_turn_ctrl.sv
// Turn sequencer in front of the connect4 board engine: tags user moves with the player to move,
// issues them over the op handshake and reports one event per move.
// Latency: mv fire -> c4_op_valid 1 cycle; c4_re fire -> ev_valid 1 cycle; ev fire -> mv_ready 1 cycle.
// Backpressure: one move in flight; op/ev held stable until their ready, mv_ready low until the event is consumed.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   mv_valid/mv_ready/mv_col            user column selection stream
//   c4_op_valid/ready/player_id/col_id  move issued to connect4
//   c4_re_valid/ready/err/is_finished/winner/tie   result returned by connect4
//   ev_valid/ready/code/player/move_num event to the reporter (code 0=OK 1=ERR 2=WIN 3=TIE)
//   score0, score1, game_cnt            saturating statistics
//
// Build option: define CONNECT4_TURN_CTRL_STATS_EN to instantiate the win/game counters;
// otherwise score0, score1 and game_cnt are tied to 0.

module connect4_turn_ctrl #(
    parameter int SCORE_W      = 8,
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mv_valid,
    output logic               mv_ready,
    input  logic [2:0]         mv_col,
    input  logic               c4_op_ready,
    output logic               c4_op_valid,
    output logic               c4_op_player_id,
    output logic [2:0]         c4_op_col_id,
    input  logic               c4_re_valid,
    output logic               c4_re_ready,
    input  logic               c4_re_err,
    input  logic               c4_re_is_finished,
    input  logic               c4_re_winner,
    input  logic               c4_re_tie,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [1:0]         ev_code,
    output logic               ev_player,
    output logic [5:0]         ev_move_num,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] game_cnt
);

    localparam logic [1:0] EV_OK  = 2'd0;
    localparam logic [1:0] EV_ERR = 2'd1;
    localparam logic [1:0] EV_WIN = 2'd2;
    localparam logic [1:0] EV_TIE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic       cur_player, cur_player_nxt;
    logic       starter, starter_nxt;
    logic [5:0] move_cnt, move_cnt_nxt;
    logic [5:0] move_inc;

    logic       mv_ready_nxt, op_valid_nxt, op_player_nxt, re_ready_nxt, ev_valid_nxt;
    logic [2:0] op_col_nxt;
    logic [1:0] ev_code_nxt;
    logic       ev_player_nxt;
    logic [5:0] ev_move_num_nxt;

    logic mv_fire, op_fire, re_fire, ev_fire;

    assign mv_fire = mv_valid & mv_ready;
    assign op_fire = c4_op_valid & c4_op_ready;
    assign re_fire = c4_re_valid & c4_re_ready;
    assign ev_fire = ev_valid & ev_ready;

    // Saturates rather than wrapping should connect4 ever fail to finish a game.
    assign move_inc = (move_cnt == 6'h3f) ? move_cnt : move_cnt + 6'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mv_fire) state_nxt = ISSUE;
            ISSUE:   if (op_fire) state_nxt = WAIT_RE;
            WAIT_RE: if (re_fire) state_nxt = REPORT;
            REPORT:  if (ev_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values; everything is registered below.
    always_comb begin
        mv_ready_nxt    = mv_ready;
        op_valid_nxt    = c4_op_valid;
        op_player_nxt   = c4_op_player_id;
        op_col_nxt      = c4_op_col_id;
        re_ready_nxt    = c4_re_ready;
        ev_valid_nxt    = ev_valid;
        ev_code_nxt     = ev_code;
        ev_player_nxt   = ev_player;
        ev_move_num_nxt = ev_move_num;
        cur_player_nxt  = cur_player;
        starter_nxt     = starter;
        move_cnt_nxt    = move_cnt;
        case (state)
            IDLE: begin
                if (mv_fire) begin
                    mv_ready_nxt  = 1'b0;
                    op_valid_nxt  = 1'b1;
                    op_col_nxt    = mv_col;
                    op_player_nxt = cur_player;
                end
            end
            ISSUE: begin
                if (op_fire) begin
                    op_valid_nxt = 1'b0;
                    re_ready_nxt = 1'b1;
                end
            end
            WAIT_RE: begin
                if (re_fire) begin
                    re_ready_nxt  = 1'b0;
                    ev_valid_nxt  = 1'b1;
                    ev_player_nxt = c4_op_player_id;
                    if (c4_re_err) begin
                        // Rejected move: same player retries, piece count unchanged.
                        ev_code_nxt     = EV_ERR;
                        ev_move_num_nxt = move_cnt;
                    end else begin
                        ev_move_num_nxt = move_inc;
                        if (c4_re_is_finished) begin
                            // connect4 clears tie when a win is found, so tie wins the decode.
                            ev_code_nxt    = c4_re_tie ? EV_TIE : EV_WIN;
                            move_cnt_nxt   = 6'd0;
                            starter_nxt    = ~starter;
                            cur_player_nxt = ~starter;
                        end else begin
                            ev_code_nxt    = EV_OK;
                            move_cnt_nxt   = move_inc;
                            cur_player_nxt = ~cur_player;
                        end
                    end
                end
            end
            REPORT: begin
                if (ev_fire) begin
                    ev_valid_nxt = 1'b0;
                    mv_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_ready        <= 1'b1;
            c4_op_valid     <= 1'b0;
            c4_op_player_id <= FIRST_PLAYER;
            c4_op_col_id    <= 3'd0;
            c4_re_ready     <= 1'b0;
            ev_valid        <= 1'b0;
            ev_code         <= EV_OK;
            ev_player       <= 1'b0;
            ev_move_num     <= 6'd0;
            cur_player      <= FIRST_PLAYER;
            starter         <= FIRST_PLAYER;
            move_cnt        <= 6'd0;
        end else begin
            mv_ready        <= mv_ready_nxt;
            c4_op_valid     <= op_valid_nxt;
            c4_op_player_id <= op_player_nxt;
            c4_op_col_id    <= op_col_nxt;
            c4_re_ready     <= re_ready_nxt;
            ev_valid        <= ev_valid_nxt;
            ev_code         <= ev_code_nxt;
            ev_player       <= ev_player_nxt;
            ev_move_num     <= ev_move_num_nxt;
            cur_player      <= cur_player_nxt;
            starter         <= starter_nxt;
            move_cnt        <= move_cnt_nxt;
        end
    end

`ifdef CONNECT4_TURN_CTRL_STATS_EN
    localparam logic [SCORE_W-1:0] CNT_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

    logic game_done, win0, win1;

    assign game_done = re_fire & ~c4_re_err & c4_re_is_finished;
    assign win0      = game_done & ~c4_re_tie & ~c4_re_winner;
    assign win1      = game_done & ~c4_re_tie &  c4_re_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score0   <= '0;
            score1   <= '0;
            game_cnt <= '0;
        end else begin
            if (win0 && score0 != '1)       score0   <= score0 + CNT_ONE;
            if (win1 && score1 != '1)       score1   <= score1 + CNT_ONE;
            if (game_done && game_cnt != '1) game_cnt <= game_cnt + CNT_ONE;
        end
    end
`else
    assign score0   = '0;
    assign score1   = '0;
    assign game_cnt = '0;

    // Winner is only consumed by the counters.
    logic unused_winner;
    assign unused_winner = c4_re_winner;
`endif

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Self-checking bench for connect4_turn_ctrl: a behavioural connect4 board answers each issued move,
// and a game-rule reference model predicts tags, events and statistics.
// Directed scenarios first, then randomized moves and handshake delays.

module tb_connect4_turn_ctrl;

    localparam int SCORE_W = 3;
    localparam int SMAX    = 7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mv_valid = 1'b0;
    logic               mv_ready;
    logic [2:0]         mv_col = 3'd0;
    logic               c4_op_ready = 1'b0;
    logic               c4_op_valid;
    logic               c4_op_player_id;
    logic [2:0]         c4_op_col_id;
    logic               c4_re_valid = 1'b0;
    logic               c4_re_ready;
    logic               c4_re_err = 1'b0;
    logic               c4_re_is_finished = 1'b0;
    logic               c4_re_winner = 1'b0;
    logic               c4_re_tie = 1'b0;
    logic               ev_valid;
    logic               ev_ready = 1'b0;
    logic [1:0]         ev_code;
    logic               ev_player;
    logic [5:0]         ev_move_num;
    logic [SCORE_W-1:0] score0, score1, game_cnt;

    connect4_turn_ctrl #(.SCORE_W(SCORE_W), .FIRST_PLAYER(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_col(mv_col),
        .c4_op_ready(c4_op_ready), .c4_op_valid(c4_op_valid),
        .c4_op_player_id(c4_op_player_id), .c4_op_col_id(c4_op_col_id),
        .c4_re_valid(c4_re_valid), .c4_re_ready(c4_re_ready),
        .c4_re_err(c4_re_err), .c4_re_is_finished(c4_re_is_finished),
        .c4_re_winner(c4_re_winner), .c4_re_tie(c4_re_tie),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_player(ev_player), .ev_move_num(ev_move_num),
        .score0(score0), .score1(score1), .game_cnt(game_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- behavioural connect4 board ----------------
    int grid [0:6][0:5];
    int hgt  [0:6];
    int pieces;

    task automatic board_clear();
        for (int c = 0; c < 7; c++) begin
            hgt[c] = 0;
            for (int r = 0; r < 6; r++) grid[c][r] = -1;
        end
        pieces = 0;
    endtask

    function automatic bit has_four(input int p);
        int dc [4] = '{1, 0, 1, 1};
        int dr [4] = '{0, 1, 1, -1};
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                for (int d = 0; d < 4; d++) begin
                    int n = 0;
                    for (int k = 0; k < 4; k++) begin
                        int cc = c + k * dc[d];
                        int rr = r + k * dr[d];
                        if (cc >= 0 && cc < 7 && rr >= 0 && rr < 6 && grid[cc][rr] == p) n++;
                    end
                    if (n == 4) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic board_play(input int col, input int p,
                              output bit err, output bit fin, output bit win, output bit tie);
        err = 0; fin = 0; win = 0; tie = 0;
        if (col > 6 || hgt[col] == 6) begin
            err = 1;
        end else begin
            grid[col][hgt[col]] = p;
            hgt[col]++;
            pieces++;
            if (has_four(p)) begin
                fin = 1; win = p[0];
            end else if (pieces == 42) begin
                fin = 1; tie = 1;
            end
            if (fin) board_clear();
        end
    endtask

    // ---------------- game-rule reference model ----------------
    int m_player, m_starter, m_move, m_s0, m_s1, m_games;

    task automatic model_reset();
        m_player = 0; m_starter = 0; m_move = 0;
        m_s0 = 0; m_s1 = 0; m_games = 0;
        board_clear();
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SMAX) ? SMAX : v + 1;
    endfunction

    task automatic model_result(input bit err, input bit fin, input bit win, input bit tie,
                                output int code, output int num);
        if (err) begin
            code = 1; num = m_move;
        end else begin
            num = m_move + 1;
            if (!fin) begin
                code = 0; m_move++; m_player = 1 - m_player;
            end else begin
                code = tie ? 3 : 2;
                m_move = 0; m_starter = 1 - m_starter; m_player = m_starter;
                m_games = sat_inc(m_games);
                if (!tie) begin
                    if (win) m_s1 = sat_inc(m_s1);
                    else     m_s0 = sat_inc(m_s0);
                end
            end
        end
    endtask

    function automatic int exp_stat(input int v);
`ifdef CONNECT4_TURN_CTRL_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic chk_stats(input string tag);
        chk({tag, "_score0"},   32'(score0),   exp_stat(m_s0));
        chk({tag, "_score1"},   32'(score1),   exp_stat(m_s1));
        chk({tag, "_game_cnt"}, 32'(game_cnt), exp_stat(m_games));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mv_ready"},    32'(mv_ready), 1);
        chk({tag, "_op_valid"},    32'(c4_op_valid), 0);
        chk({tag, "_re_ready"},    32'(c4_re_ready), 0);
        chk({tag, "_ev_valid"},    32'(ev_valid), 0);
        chk({tag, "_ev_code"},     32'(ev_code), 0);
        chk({tag, "_ev_player"},   32'(ev_player), 0);
        chk({tag, "_ev_move_num"}, 32'(ev_move_num), 0);
        chk({tag, "_op_col"},      32'(c4_op_col_id), 0);
        chk({tag, "_op_player"},   32'(c4_op_player_id), 0);
        chk({tag, "_score0"},      32'(score0), 0);
        chk({tag, "_score1"},      32'(score1), 0);
        chk({tag, "_game_cnt"},    32'(game_cnt), 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        mv_valid = 0; c4_op_ready = 0; c4_re_valid = 0; ev_ready = 0;
        rst_n = 0;
        step();
        chk_reset_vals(tag);
        rst_n = 1;
        model_reset();
        step();
    endtask

    // One complete move through all three handshakes with the given stall lengths.
    task automatic do_move(input int col, input int op_dly, input int re_dly, input int ev_dly,
                           output int o_code, output int o_player, output int o_num);
        int n;
        bit err, fin, win, tie;
        int ecode, enum_v, eplayer;
        n = 0;
        while (!mv_ready && n < 50) begin step(); n++; end
        chk("mv_ready_wait", 32'(mv_ready), 1);
        mv_valid = 1; mv_col = col[2:0];
        step();
        mv_valid = 0; mv_col = 3'($urandom);
        chk("op_valid_lat", 32'(c4_op_valid), 1);
        chk("op_player",    32'(c4_op_player_id), m_player);
        chk("op_col",       32'(c4_op_col_id), col);
        chk("mv_ready_busy", 32'(mv_ready), 0);
        for (int i = 0; i < op_dly; i++) begin
            c4_re_valid = 1'($urandom); c4_re_err = 1'($urandom); c4_re_is_finished = 1'($urandom);
            step();
            chk("stall_op_valid",  32'(c4_op_valid), 1);
            chk("stall_op_col",    32'(c4_op_col_id), col);
            chk("stall_op_player", 32'(c4_op_player_id), m_player);
            chk("stall_mv_ready",  32'(mv_ready), 0);
            chk("stall_re_ready",  32'(c4_re_ready), 0);
        end
        c4_re_valid = 0;
        c4_op_ready = 1;
        step();
        c4_op_ready = 0;
        chk("op_done_valid", 32'(c4_op_valid), 0);
        chk("re_ready_up",   32'(c4_re_ready), 1);
        eplayer = m_player;
        board_play(col, m_player, err, fin, win, tie);
        model_result(err, fin, win, tie, ecode, enum_v);
        for (int i = 0; i < re_dly; i++) begin
            step();
            chk("re_wait_ready", 32'(c4_re_ready), 1);
            chk("re_wait_ev",    32'(ev_valid), 0);
        end
        c4_re_valid = 1; c4_re_err = err; c4_re_is_finished = fin; c4_re_tie = tie;
        c4_re_winner = (fin && !tie) ? win : 1'($urandom);
        step();
        c4_re_valid = 0; c4_re_tie = 0;
        chk("ev_valid_lat", 32'(ev_valid), 1);
        chk("re_ready_down", 32'(c4_re_ready), 0);
        chk("ev_code",      32'(ev_code), ecode);
        chk("ev_player",    32'(ev_player), eplayer);
        chk("ev_move_num",  32'(ev_move_num), enum_v);
        o_code = int'(ev_code); o_player = int'(ev_player); o_num = int'(ev_move_num);
        for (int i = 0; i < ev_dly; i++) begin
            c4_re_valid = 1'($urandom);
            step();
            chk("evstall_valid",    32'(ev_valid), 1);
            chk("evstall_code",     32'(ev_code), ecode);
            chk("evstall_player",   32'(ev_player), eplayer);
            chk("evstall_num",      32'(ev_move_num), enum_v);
            chk("evstall_mv_ready", 32'(mv_ready), 0);
        end
        c4_re_valid = 0;
        ev_ready = 1;
        step();
        ev_ready = 0;
        chk("ev_done_valid", 32'(ev_valid), 0);
        chk("ev_done_mv_ready", 32'(mv_ready), 1);
        chk_stats("post_ev");
    endtask

    int tie_seq [42] = '{0,0,0,0,0,0, 1,1,1,1,1,1, 4, 2,2,2,2,2,2, 3,3,3,3,3,3,
                         4, 5, 6,6,6,6,6,6, 5, 4,4,4,4, 5,5,5,5};

    initial begin
        int code, pl, num;

        // Reset, first move OK, second move tagged player 1
        do_reset("rst");
        do_move(3, 0, 0, 0, code, pl, num);
        chk("first_code", code, 0);
        chk("first_player", pl, 0);
        chk("first_num", num, 1);
        do_move(4, 0, 1, 0, code, pl, num);
        chk("second_player", pl, 1);

        // op_ready held low for 5 cycles
        do_move(2, 5, 2, 0, code, pl, num);

        // Column full: 6 pieces in col 0, 7th rejected, retry same player
        do_reset("rst_full");
        for (int i = 0; i < 6; i++) do_move(0, 0, 0, 0, code, pl, num);
        do_move(0, 1, 0, 0, code, pl, num);
        chk("full_code", code, 1);
        chk("full_num", num, 6);
        chk("full_player", pl, 0);
        do_move(1, 0, 0, 0, code, pl, num);
        chk("retry_player", pl, 0);
        chk("retry_num", num, 7);

        // Vertical win for player 0, then starter toggles
        do_reset("rst_win");
        for (int i = 0; i < 7; i++) do_move(i % 2, 0, 0, 0, code, pl, num);
        chk("win_code", code, 2);
        chk("win_player", pl, 0);
        chk("win_score0", 32'(score0), exp_stat(1));
        chk("win_game_cnt", 32'(game_cnt), exp_stat(1));
        do_move(3, 0, 0, 0, code, pl, num);
        chk("newgame_player", pl, 1);
        chk("newgame_num", num, 1);

        // Full-board tie, with a long ev_ready stall on the last event
        do_reset("rst_tie");
        for (int i = 0; i < 42; i++)
            do_move(tie_seq[i], 0, 0, (i == 41) ? 10 : 0, code, pl, num);
        chk("tie_code", code, 3);
        chk("tie_num", num, 42);
        chk("tie_game_cnt", 32'(game_cnt), exp_stat(1));
        chk("tie_score0", 32'(score0), 0);
        chk("tie_score1", 32'(score1), 0);

        // Reset asserted while waiting for the result
        do_reset("rst_mid_pre");
        mv_valid = 1; mv_col = 3'd5;
        step();
        mv_valid = 0;
        c4_op_ready = 1;
        step();
        c4_op_ready = 0;
        chk("mid_re_ready", 32'(c4_re_ready), 1);
        rst_n = 0;
        #1;
        chk_reset_vals("rst_mid");
        step();
        rst_n = 1;
        model_reset();
        step();

        // Randomized play
        for (int i = 0; i < 400; i++) begin
            int col;
            col = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
            do_move(col, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    code, pl, num);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/connect4_turn_ctrl.md
Name: connect4_turn_ctrl

Overview:
- Game sequencer directly upstream of the connect4 board engine.
- Accepts raw column selections from the user-input stream and tags each with the player whose turn it is.
- Issues each move to connect4 over its op handshake, consumes the re result, and emits one event per move to the display/UART reporter.
- Tracks turn order, move number, starting player per game, and (optionally) scores.

Parameters:
- SCORE_W, 8, width of per-player win counters and game counter.
- FIRST_PLAYER, 0, player id that starts the first game after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mv_valid  in  1  user move valid
- mv_ready  out  1  controller can take a move
- mv_col  in  3  column 0..6; 7 is passed through and rejected by connect4 as out-of-board
- c4_op_ready  in  1  from connect4 op_ready
- c4_op_valid  out  1  to connect4 op_valid
- c4_op_player_id  out  1  to connect4 op_player_id
- c4_op_col_id  out  3  to connect4 op_col_id
- c4_re_valid  in  1  from connect4 re_valid
- c4_re_ready  out  1  to connect4 re_ready
- c4_re_err, c4_re_is_finished, c4_re_winner, c4_re_tie  in  1 each  connect4 result fields
- ev_valid  out  1  event valid
- ev_ready  in  1  event consumer ready
- ev_code  out  2  0=OK, 1=ERR (column full), 2=WIN, 3=TIE
- ev_player  out  1  player who made the move
- ev_move_num  out  6  accepted pieces in current game incl. this one (0..42)
- score0, score1  out  SCORE_W  wins per player
- game_cnt  out  SCORE_W  completed games (win or tie)

Behaviour:
- All outputs are registered. Fire = valid & ready, sampled on the clk rising edge.
- Reset values:
  - mv_ready=1; c4_op_valid=0; c4_re_ready=0; ev_valid=0.
  - ev_code=0, ev_player=0, ev_move_num=0; c4_op_col_id=0.
  - c4_op_player_id=FIRST_PLAYER; cur_player=FIRST_PLAYER; starter=FIRST_PLAYER; move_cnt=0.
  - Scores and game_cnt = 0.
- FSM states: IDLE, ISSUE, WAIT_RE, REPORT.
- IDLE:
  - mv_ready=1.
  - On mv fire: latch c4_op_col_id=mv_col and c4_op_player_id=cur_player; next cycle mv_ready=0, c4_op_valid=1 → ISSUE.
- ISSUE:
  - c4_op_valid held high, and col/player held stable, until c4_op_ready.
  - On fire: c4_op_valid=0, c4_re_ready=1 → WAIT_RE.
- WAIT_RE:
  - On c4_re fire: c4_re_ready=0, ev_valid=1, ev_player=c4_op_player_id → REPORT.
  - ev_code: err→1; else finished&tie→3; else finished→2; else 0.
  - If err: move_cnt unchanged; ev_move_num=move_cnt; cur_player unchanged (same player retries).
  - If not err: ev_move_num=move_cnt+1.
    - Not finished: move_cnt+=1, cur_player toggles.
    - Finished: move_cnt=0; starter toggles; cur_player=new starter; game_cnt+=1.
    - Finished & !tie: score of c4_re_winner += 1.
- REPORT:
  - ev_valid and all ev fields held until ev_ready.
  - On fire: ev_valid=0, mv_ready=1 → IDLE.
- Latency:
  - mv fire to c4_op_valid: 1 cycle.
  - c4_re fire to ev_valid: 1 cycle.
  - ev fire to mv_ready: 1 cycle.
- Exactly one move is in flight; no new move is accepted before the event is consumed.
- Boundaries:
  - c4_re_winner is trusted; it is not cross-checked against ev_player.
  - A win on move 42 reports WIN (connect4 clears tie when a win is found).
  - Counters saturate at all-ones and never wrap.
  - c4_re_valid outside WAIT_RE is ignored (c4_re_ready=0).
- Reset mid-operation: immediate return to reset values. connect4 shares rst_n, so board and controller stay consistent; no partial event is emitted.

Optional Feature:
- Macro: CONNECT4_TURN_CTRL_STATS_EN.
- Defined: score0, score1 and game_cnt are counted as above.
- Undefined:
  - Counters are not instantiated and the three ports are tied to 0.
  - Starter alternation and move numbering are unaffected.

Test Plan:
- Reset, FIRST_PLAYER=0, move col 3 → c4_op_valid 1 cycle later with player=0, col=3; result OK → ev_code=0, ev_player=0, ev_move_num=1; next move is tagged player 1.
- c4_op_ready held low 5 cycles after op_valid → c4_op_valid stays 1 with col/player stable; mv_ready stays 0 throughout.
- Fill col 0 with 6 pieces, 7th move col 0 → ev_code=1, ev_move_num=6; retry is tagged the same player; move_cnt unchanged.
- Player 0 plays cols 0,0,0,0 while player 1 plays 1,1,1 → 7th event ev_code=2, ev_player=0, score0=1, game_cnt=1; next move tagged player 1 (starter toggled), ev_move_num=1.
- 42-move tie sequence → final ev_code=3, ev_move_num=42, game_cnt=1, scores unchanged.
- ev_ready held low 10 cycles → ev_valid and fields stable, mv_ready=0. Separately: rst_n low during WAIT_RE → all outputs return to reset values asynchronously.
